hazard_ctrl: RTL

Parametrised pipeline hazard controller for the five-stage core. It replaces the fixed load-use and jump-use flag unit with a stateful controller. The controller takes pre-decoded register fields from the decode, execute and memory stages. It drives the PC and the inter-stage latch enables and flushes, and supports a configurable number of load-use bubbles, register-indirect jump stalls, taken-branch and jump flushes, memory-wait freeze, and saturating event counters for performance debug.

---
 rtl/hazard_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Stateful hazard controller for the five-stage core. Detects load-use and
// register-indirect jump (jr) hazards from pre-decoded register fields, resolves
// taken-branch / jump flushes and memory-wait freeze, and drives the PC and
// inter-stage latch enables and flushes. Two saturating event counters
// (load-use stalls, front-end flushes) are kept for performance debug.
//
// Parameters
//   REG_W         register index width
//   LOAD_BUBBLES  bubbles inserted per load-use hazard (1..4)
//   CNT_W         width of the event counters
//
// Ports
//   CLK, nRST                    clock (rising edge), async active-low reset
//   mem_wait                     memory not ready: freeze whole pipe
//   dec_rs/dec_rt/dec_use_rs/dec_use_rt/dec_jr/dec_jump  decode-stage info
//   ex_valid/ex_load/ex_regwr/ex_wsel                    execute-stage info
//   mem_valid/mem_load/mem_wsel                          memory-stage info
//   ex_br_taken                  branch resolved taken in execute
//   pc_en, fd_en, de_en          PC, F/D and D/E latch enables
//   fd_flush, de_flush           load a bubble into F/D or D/E
//   stall                        hazard stall active this cycle
//   lu_cnt, flush_cnt            saturating event counters
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int REG_W        = 5,
  parameter int LOAD_BUBBLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             mem_wait,
  input  logic [REG_W-1:0] dec_rs,
  input  logic [REG_W-1:0] dec_rt,
  input  logic             dec_use_rs,
  input  logic             dec_use_rt,
  input  logic             dec_jr,
  input  logic             dec_jump,
  input  logic             ex_valid,
  input  logic             ex_load,
  input  logic             ex_regwr,
  input  logic [REG_W-1:0] ex_wsel,
  input  logic             mem_valid,
  input  logic             mem_load,
  input  logic [REG_W-1:0] mem_wsel,
  input  logic             ex_br_taken,
  output logic             pc_en,
  output logic             fd_en,
  output logic             de_en,
  output logic             fd_flush,
  output logic             de_flush,
  output logic             stall,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int LEFT_W = $clog2(LOAD_BUBBLES + 1);

  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [LEFT_W-1:0]   r_left;
  logic [LEFT_W-1:0]   w_left_nxt;
  logic [CNT_W-1:0]    r_lu_cnt;
  logic [CNT_W-1:0]    r_flush_cnt;
  logic                w_lu_inc;
  logic                w_flush_inc;
  logic                w_lu;
  logic                w_ju;
  logic                w_ex_nz;
  logic                w_mem_nz;

  // Counters stick at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Register 0 is hardwired, so a zero destination never creates a hazard.
  assign w_ex_nz  = (ex_wsel  != '0);
  assign w_mem_nz = (mem_wsel != '0);

  assign w_lu = ex_valid & ex_load & w_ex_nz &
                ((dec_use_rs & (dec_rs == ex_wsel)) |
                 (dec_use_rt & (dec_rt == ex_wsel)));

  // jr reads rs in decode, so it must wait for any ALU result still in EX as
  // well as a load still in MEM (no forwarding into decode for either).
  assign w_ju = dec_jr &
                ((ex_valid  & ex_regwr & w_ex_nz  & (ex_wsel  == dec_rs)) |
                 (mem_valid & mem_load & w_mem_nz & (mem_wsel == dec_rs)));

  // Priority: mem_wait > branch > ongoing stall > lu > ju > jump > run.
  always_comb begin
    pc_en       = 1'b1;
    fd_en       = 1'b1;
    de_en       = 1'b1;
    fd_flush    = 1'b0;
    de_flush    = 1'b0;
    stall       = 1'b0;
    w_state_nxt = r_state;
    w_left_nxt  = r_left;
    w_lu_inc    = 1'b0;
    w_flush_inc = 1'b0;

    if (mem_wait) begin
      pc_en = 1'b0;
      fd_en = 1'b0;
      de_en = 1'b0;
    end else if (ex_br_taken) begin
      fd_flush    = 1'b1;
      de_flush    = 1'b1;
      w_state_nxt = RUN;
      w_left_nxt  = '0;
      w_flush_inc = 1'b1;
    end else if (r_state == LU_STALL) begin
      pc_en      = 1'b0;
      fd_en      = 1'b0;
      de_flush   = 1'b1;
      stall      = 1'b1;
      w_left_nxt = r_left - LEFT_W'(1);
      // left <= 1 also covers an unexpected zero so the FSM cannot stick.
      if (r_left <= LEFT_W'(1)) begin
        w_state_nxt = RUN;
        w_left_nxt  = '0;
      end
    end else if (w_lu) begin
      pc_en    = 1'b0;
      fd_en    = 1'b0;
      de_flush = 1'b1;
      stall    = 1'b1;
      w_lu_inc = 1'b1;
      // First bubble is this cycle; the rest are counted down in LU_STALL.
      if (LOAD_BUBBLES > 1) begin
        w_state_nxt = LU_STALL;
        w_left_nxt  = LEFT_W'(LOAD_BUBBLES - 1);
      end
    end else if (w_ju) begin
      pc_en    = 1'b0;
      fd_en    = 1'b0;
      de_flush = 1'b1;
      stall    = 1'b1;
    end else if (dec_jump) begin
      fd_flush    = 1'b1;
      w_flush_inc = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= RUN;
      r_left      <= '0;
      r_lu_cnt    <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_left  <= w_left_nxt;
      if (w_lu_inc) begin
        r_lu_cnt <= sat_inc(r_lu_cnt);
      end
      if (w_flush_inc) begin
        r_flush_cnt <= sat_inc(r_flush_cnt);
      end
    end
  end

  assign lu_cnt    = r_lu_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule
